// File: rtl/mm_operand_loader_if.sv
// rtl/mm_operand_loader_if.sv - operand beat input and matrix-pair output bundle
// master = loader side, slave = feeder/core side.
interface mm_operand_loader_if #(
  parameter int DIM = 2,
  parameter int EW  = 4
);
  localparam int NE = DIM * DIM;

  logic [7:0]       ui_in;
  logic [7:0]       uio_in;
  logic             in_valid;
  logic             in_ready;
  logic [NE*EW-1:0] mat_a;
  logic [NE*EW-1:0] mat_b;
  logic             op_valid;
  logic             op_ready;

  modport master (
    input  ui_in, uio_in, in_valid, op_ready,
    output in_ready, mat_a, mat_b, op_valid
  );

  modport slave (
    output ui_in, uio_in, in_valid, op_ready,
    input  in_ready, mat_a, mat_b, op_valid
  );
endinterface

// File: rtl/mm_operand_loader.sv
// rtl/mm_operand_loader.sv - collects A/B operand beats into matrix pairs for the multiply core
// FILL gathers NBEAT beats; HOLD presents the pair until the core handshakes it.
module mm_operand_loader #(
  parameter int DIM = 2,
  parameter int EW  = 4,
  localparam int EPB   = 8 / EW,
  localparam int NE    = DIM * DIM,
  localparam int NBEAT = NE / EPB,
  localparam int BW    = $clog2(NBEAT + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                clear,
  mm_operand_loader_if.master bus,
  output logic [BW-1:0]       beat_cnt,
  output logic [7:0]          set_cnt,
  output logic                overrun
);

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [BW-1:0]    cnt_d;
  logic [7:0]       set_d;
  logic             ovr_d;
  logic [NE*EW-1:0] mat_a_q, mat_a_d;
  logic [NE*EW-1:0] mat_b_q, mat_b_d;
  logic             ready;
  logic             accept;
  logic             handshake;

  assign ready     = ena & ~clear & ((state_q == FILL) | bus.op_ready);
  assign accept    = bus.in_valid & ready;
  assign handshake = ena & ~clear & (state_q == HOLD) & bus.op_ready;

  assign bus.in_ready = ready;
  assign bus.op_valid = (state_q == HOLD);
  assign bus.mat_a    = mat_a_q;
  assign bus.mat_b    = mat_b_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = beat_cnt;
    set_d   = set_cnt;
    ovr_d   = overrun;
    mat_a_d = mat_a_q;
    mat_b_d = mat_b_q;

    if (clear) begin
      state_d = FILL;
      cnt_d   = '0;
      ovr_d   = 1'b0;
    end else if (ena) begin
      if (bus.in_valid & ~ready)
        ovr_d = 1'b1;

      if (handshake) begin
        set_d   = set_cnt + 8'd1;
        state_d = FILL;
      end

      // A beat accepted alongside a handshake starts the next pair in place.
      if (accept) begin
        for (int i = 0; i < NE; i++) begin
          if (int'(beat_cnt) == i / EPB) begin
            mat_a_d[i*EW +: EW] = bus.ui_in[(i % EPB)*EW +: EW];
            mat_b_d[i*EW +: EW] = bus.uio_in[(i % EPB)*EW +: EW];
          end
        end
        if (beat_cnt == BW'(NBEAT - 1)) begin
          cnt_d   = '0;
          state_d = HOLD;
        end else begin
          cnt_d = beat_cnt + BW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FILL;
      beat_cnt <= '0;
      set_cnt  <= '0;
      overrun  <= 1'b0;
      mat_a_q  <= '0;
      mat_b_q  <= '0;
    end else begin
      state_q  <= state_d;
      beat_cnt <= cnt_d;
      set_cnt  <= set_d;
      overrun  <= ovr_d;
      mat_a_q  <= mat_a_d;
      mat_b_q  <= mat_b_d;
    end
  end

endmodule

// File: tb/tb_mm_operand_loader.sv
// tb/tb_mm_operand_loader.sv - vector table, corner sequences and random run against a pair-level model
module tb_mm_operand_loader;
  localparam int DIM   = 2;
  localparam int EW    = 4;
  localparam int EPB   = 8 / EW;
  localparam int NE    = DIM * DIM;
  localparam int NBEAT = NE / EPB;
  localparam int BW    = $clog2(NBEAT + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ena;
  logic          clear;
  logic [BW-1:0] beat_cnt;
  logic [7:0]    set_cnt;
  logic          overrun;

  int pass_cnt  = 0;
  int total_cnt = 0;

  mm_operand_loader_if #(.DIM(DIM), .EW(EW)) bus ();

  mm_operand_loader #(.DIM(DIM), .EW(EW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .clear    (clear),
    .bus      (bus.master),
    .beat_cnt (beat_cnt),
    .set_cnt  (set_cnt),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        e, c, v;
    logic [7:0]  ui, uio;
    logic        r;
    logic        ir, ov;
    logic [15:0] a, b;
    logic [1:0]  cnt;
    logic [7:0]  set;
    logic        ovr;
  } vec_t;

  vec_t tbl[16];

  // Reference: list of element values plus a "pair is held" flag.
  int m_a[NE];
  int m_b[NE];
  int m_cnt;
  int m_set;
  bit m_hold;
  bit m_ovr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic e, c, v, input logic [7:0] ui, uio, input logic r);
    ena          = e;
    clear        = c;
    bus.in_valid = v;
    bus.ui_in    = ui;
    bus.uio_in   = uio;
    bus.op_ready = r;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NE; i++) begin
      m_a[i] = 0;
      m_b[i] = 0;
    end
    m_cnt = 0; m_set = 0; m_hold = 0; m_ovr = 0;
  endtask

  task automatic hw_reset();
    drive(0, 0, 0, 8'h00, 8'h00, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic cycle_model(input logic e, c, v, input logic [7:0] ui, uio, input logic r,
                             input string tag);
    bit exp_ready;
    logic [NE*EW-1:0] ea, eb;
    int elem;
    drive(e, c, v, ui, uio, r);
    #1;
    exp_ready = e && !c && (!m_hold || r);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'(exp_ready));
    if (c) begin
      m_hold = 0; m_cnt = 0; m_ovr = 0;
    end else if (e) begin
      if (v && !exp_ready) m_ovr = 1;
      if (m_hold && r) begin
        m_set  = (m_set + 1) % 256;
        m_hold = 0;
      end
      if (v && exp_ready) begin
        for (int j = 0; j < EPB; j++) begin
          elem = m_cnt * EPB + j;
          m_a[elem] = (int'(ui) >> (j * EW)) & ((1 << EW) - 1);
          m_b[elem] = (int'(uio) >> (j * EW)) & ((1 << EW) - 1);
        end
        m_cnt++;
        if (m_cnt == NBEAT) begin
          m_cnt  = 0;
          m_hold = 1;
        end
      end
    end
    @(posedge clk); #1;
    for (int i = 0; i < NE; i++) begin
      ea[i*EW +: EW] = m_a[i][EW-1:0];
      eb[i*EW +: EW] = m_b[i][EW-1:0];
    end
    check({tag, "_op_valid"}, 32'(bus.op_valid), 32'(m_hold));
    check({tag, "_mat_a"},    32'(bus.mat_a),    32'(ea));
    check({tag, "_mat_b"},    32'(bus.mat_b),    32'(eb));
    check({tag, "_beat_cnt"}, 32'(beat_cnt),     32'(m_cnt));
    check({tag, "_set_cnt"},  32'(set_cnt),      32'(m_set));
    check({tag, "_overrun"},  32'(overrun),      32'(m_ovr));
  endtask

  initial begin
    //            e  c  v  ui     uio    r  ir ov  mat_a     mat_b     cnt set    ovr
    tbl[0]  = '{1, 0, 1, 8'h21, 8'h65, 0, 1, 0, 16'h0021, 16'h0065, 1, 8'd0, 0};
    tbl[1]  = '{1, 0, 1, 8'h43, 8'h87, 0, 1, 1, 16'h4321, 16'h8765, 0, 8'd0, 0};
    tbl[2]  = '{1, 0, 0, 8'h00, 8'h00, 0, 0, 1, 16'h4321, 16'h8765, 0, 8'd0, 0};
    tbl[3]  = '{1, 0, 1, 8'hFF, 8'hFF, 0, 0, 1, 16'h4321, 16'h8765, 0, 8'd0, 1};
    tbl[4]  = '{1, 0, 0, 8'h00, 8'h00, 1, 1, 0, 16'h4321, 16'h8765, 0, 8'd1, 1};
    tbl[5]  = '{1, 0, 1, 8'h11, 8'h22, 0, 1, 0, 16'h4311, 16'h8722, 1, 8'd1, 1};
    tbl[6]  = '{1, 0, 1, 8'h33, 8'h44, 0, 1, 1, 16'h3311, 16'h4422, 0, 8'd1, 1};
    tbl[7]  = '{1, 0, 1, 8'hAA, 8'hBB, 1, 1, 0, 16'h33AA, 16'h44BB, 1, 8'd2, 1};
    tbl[8]  = '{1, 1, 1, 8'hCC, 8'hDD, 0, 0, 0, 16'h33AA, 16'h44BB, 0, 8'd2, 0};
    tbl[9]  = '{0, 0, 1, 8'hCC, 8'hDD, 1, 0, 0, 16'h33AA, 16'h44BB, 0, 8'd2, 0};
    tbl[10] = '{1, 0, 1, 8'h55, 8'h66, 0, 1, 0, 16'h3355, 16'h4466, 1, 8'd2, 0};
    tbl[11] = '{1, 1, 0, 8'h00, 8'h00, 0, 0, 0, 16'h3355, 16'h4466, 0, 8'd2, 0};
    tbl[12] = '{1, 0, 1, 8'h01, 8'h02, 0, 1, 0, 16'h3301, 16'h4402, 1, 8'd2, 0};
    tbl[13] = '{1, 0, 1, 8'h03, 8'h04, 0, 1, 1, 16'h0301, 16'h0402, 0, 8'd2, 0};
    tbl[14] = '{0, 0, 1, 8'hEE, 8'hEE, 1, 0, 1, 16'h0301, 16'h0402, 0, 8'd2, 0};
    tbl[15] = '{1, 1, 0, 8'h00, 8'h00, 1, 0, 0, 16'h0301, 16'h0402, 0, 8'd2, 0};

    rst_n = 1'b0;
    drive(0, 0, 0, 8'h00, 8'h00, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_op_valid", 32'(bus.op_valid), 32'd0);
    check("rst_mat_a",    32'(bus.mat_a),    32'd0);
    check("rst_beat_cnt", 32'(beat_cnt),     32'd0);
    check("rst_set_cnt",  32'(set_cnt),      32'd0);
    rst_n = 1'b1;

    for (int k = 0; k < 16; k++) begin
      drive(tbl[k].e, tbl[k].c, tbl[k].v, tbl[k].ui, tbl[k].uio, tbl[k].r);
      #1;
      check($sformatf("vec%0d_in_ready", k), 32'(bus.in_ready), 32'(tbl[k].ir));
      @(posedge clk); #1;
      check($sformatf("vec%0d_op_valid", k), 32'(bus.op_valid), 32'(tbl[k].ov));
      check($sformatf("vec%0d_mat_a", k),    32'(bus.mat_a),    32'(tbl[k].a));
      check($sformatf("vec%0d_mat_b", k),    32'(bus.mat_b),    32'(tbl[k].b));
      check($sformatf("vec%0d_beat_cnt", k), 32'(beat_cnt),     32'(tbl[k].cnt));
      check($sformatf("vec%0d_set_cnt", k),  32'(set_cnt),      32'(tbl[k].set));
      check($sformatf("vec%0d_overrun", k),  32'(overrun),      32'(tbl[k].ovr));
    end

    // Asynchronous reset mid-fill, asserted between clock edges.
    drive(1, 0, 1, 8'h5A, 8'hA5, 0);
    @(posedge clk); #1;
    check("midfill_beat_cnt", 32'(beat_cnt), 32'd1);
    #2;
    rst_n = 1'b0;
    drive(0, 0, 0, 8'h00, 8'h00, 0);
    @(posedge clk); #1;
    check("arst_beat_cnt", 32'(beat_cnt),     32'd0);
    check("arst_mat_a",    32'(bus.mat_a),    32'd0);
    check("arst_mat_b",    32'(bus.mat_b),    32'd0);
    check("arst_op_valid", 32'(bus.op_valid), 32'd0);
    check("arst_set_cnt",  32'(set_cnt),      32'd0);
    check("arst_overrun",  32'(overrun),      32'd0);
    rst_n = 1'b1;
    drive(1, 0, 0, 8'h00, 8'h00, 0);
    #1;
    check("arst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    model_reset();

    for (int n = 0; n < 2000; n++) begin
      cycle_model(($urandom_range(0, 9) != 0), ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 9) < 7), 8'($urandom), 8'($urandom),
                  ($urandom_range(0, 1) == 1), "rnd");
    end

    hw_reset();
    for (int n = 0; n < 256; n++) begin
      for (int b = 0; b < NBEAT; b++)
        cycle_model(1, 0, 1, 8'($urandom), 8'($urandom), 0, "wrap");
      cycle_model(1, 0, 0, 8'h00, 8'h00, 1, "wrap");
    end
    check("wrap_set_cnt_zero", 32'(set_cnt), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
